// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter only needs to reach width-1; keep at least one bit for width 2.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell, with valid/ready on both sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             bin_q;
    logic [CW-1:0]    count;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Handshake flags are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            bin_q     <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        bin_q    <= 1'b0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff  <= {d_bit, diff[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    bin_q <= bout_bit;
                    count <= count + 1'b1;
                    // On the last bit the cell inputs are the operand MSBs and d_bit is the result MSB.
                    if (count == LAST) begin
                        borrow    <= bout_bit;
                        overflow  <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corners, backpressure, abort, random back-to-back.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] d, output logic br, output logic ov);
        int sx, sy, sd;
        d  = x - y;
        br = (x < y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        sd = sx - sy;
        ov = (sd > 127) || (sd < -128);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] ed;
        logic         eb, eo;
        model(x, y, ed, eb, eo);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    // Full transaction from IDLE with out_ready held high.
    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_lat"}, lat, W);
        check_result(tag, x, y);
        tick();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int           lat;
        int           seen;
        int           results;
        int           last_acc;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] pa, pb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        op("basic", 8'h3C, 8'h15);
        op("neg", 8'h10, 8'h20);
        op("ovf_pos", 8'h80, 8'h01);
        op("ovf_both", 8'h7F, 8'hFF);
        op("equal", 8'hA5, 8'hA5);
        for (int i = 0; i < 4; i++) op("rand", W'($urandom), W'($urandom));

        // Backpressure: result held while new operands wait at the input.
        out_ready = 1'b0;
        a         = 8'h3C;
        b         = 8'h15;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", lat, W);
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            check("bp_hold_diff", 32'(diff), 32'h27);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_next_lat", lat, W);
        check_result("bp_next", 8'h11, 8'h22);
        tick();

        // Abort one cycle after the fourth bit is processed.
        a        = 8'h3C;
        b        = 8'h15;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("abort_no_valid", seen, 0);
        op("after_abort", 8'h3C, 8'h15);

        // Back-to-back random stream; operands change every cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        results   = 0;
        last_acc  = -1;
        for (int i = 0; i < 400 && results < 25; i++) begin
            if (out_valid) begin
                if (qa.size() == 0) begin
                    check("b2b_unexpected", 32'd1, 32'd0);
                end else begin
                    pa = qa.pop_front();
                    pb = qb.pop_front();
                    check_result("b2b", pa, pb);
                end
                results++;
            end
            if (in_ready) begin
                qa.push_back(a);
                qb.push_back(b);
                if (last_acc >= 0) check("b2b_interval", i - last_acc, W + 2);
                last_acc = i;
            end
            tick();
            a = W'($urandom);
            b = W'($urandom);
        end
        check("b2b_count", results, 25);
        in_valid = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
